eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single 8-bit AXI-stream TX input of the 10/100 MII MAC between PORTS frame sources, for example the RTPS packet builder and the ARP/ICMP responder.
- Arbitration is round-robin at frame granularity. Once a port is granted, its whole frame passes through uninterrupted.
- Sits in the MAC tx_clk domain, directly upstream of the MAC tx_axis port.

Parameters:
- PORTS, 2, number of requesting source ports (2..8).
- TIMEOUT_CYCLES, 1024, mid-frame stall limit in cycles; used only when the watchdog is enabled.

Ports:
- clk  input  1  tx clock (MAC tx_clk).
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  PORTS*8  source data; port i occupies bits [8i+7:8i].
- s_axis_tvalid  input  PORTS  per-port valid.
- s_axis_tready  output  PORTS  per-port ready.
- s_axis_tlast  input  PORTS  per-port end of frame.
- s_axis_tuser  input  PORTS  per-port bad-frame flag.
- m_axis_tdata  output  8  to MAC tx_axis_tdata.
- m_axis_tvalid  output  1  to MAC tx_axis_tvalid.
- m_axis_tready  input  1  from MAC tx_axis_tready.
- m_axis_tlast  output  1  to MAC tx_axis_tlast.
- m_axis_tuser  output  1  to MAC tx_axis_tuser.
- grant_valid  output  1  a frame is in progress.
- grant_idx  output  3  index of the granted port.
- frame_count  output  16  count of completed output frames.
- abort_pulse  output  1  one-cycle pulse when a frame is aborted (watchdog only).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=PORTS-1 (port 0 wins first), grant_idx=0.
  - grant_valid=0, frame_count=0, abort_pulse=0.
  - All s_axis_tready=0; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=0.
- States: IDLE, XFER, ABORT, DRAIN.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is set, choose the first set port scanning from last_grant+1 modulo PORTS.
  - Register that port into grant_idx, set grant_valid=1, and go to XFER on the next clock.
  - Arbitration latency is one cycle. There is always at least one IDLE cycle between frames.
- XFER:
  - Combinational pass-through of the granted port: m_axis_tdata/tvalid/tlast/tuser = s_axis_*[grant_idx], and s_axis_tready[grant_idx] = m_axis_tready.
  - Every other s_axis_tready stays 0.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast: last_grant<=grant_idx, grant_valid<=0, frame_count<=frame_count+1 (wraps 0xFFFF->0), go to IDLE.
- Round-robin examples:
  - Simultaneous requests always follow rotation order.
  - A lone requester is re-granted after each frame with one IDLE cycle between frames.
  - A port that drops tvalid while IDLE simply loses that arbitration round.
- The grant is never changed mid-frame. A source must not deassert tvalid expecting a release; only tlast releases the grant.
- Reset asserted mid-frame returns to IDLE immediately. The partial frame is cut off; the MAC underflow path handles it.
- ABORT and DRAIN are reachable only with the watchdog enabled.

Optional Feature:
- Macro: ETH_TX_ARB_WATCHDOG_EN.
- Defined:
  - A 16-bit stall counter clears on entry to XFER and on every cycle where s_axis_tvalid[grant_idx]=1.
  - It increments otherwise while in XFER.
  - When it reaches TIMEOUT_CYCLES, go to ABORT.
- ABORT:
  - Drive m_axis_tvalid=1, tdata=0x00, tlast=1, tuser=1. All s_axis_tready=0.
  - On m_axis_tready: pulse abort_pulse for one cycle, increment frame_count, go to DRAIN.
- DRAIN:
  - s_axis_tready[grant_idx]=1 and m_axis_tvalid=0.
  - Discard beats until a beat with s_axis_tvalid & s_axis_tlast.
  - Then last_grant<=grant_idx, grant_valid<=0, go to IDLE.
- Not defined: no counter is present and abort_pulse is tied 0. A stalled source holds the grant indefinitely.

Test Plan:
- Single frame: port 0 sends 60 bytes 0x01..0x3C with m_axis_tready=1 -> bytes appear unchanged on m_axis with tlast on byte 60; grant_idx=0; frame_count=1; no s_axis_tready on port 1.
- Contention: ports 0 and 1 both request a 64-byte frame at the same cycle after reset -> port 0 is sent first, then one IDLE cycle, then port 1; frame_count=2.
- Fairness: port 0 sends back-to-back frames continuously while port 1 requests once -> order is p0, p1, p0.
- Backpressure: m_axis_tready toggles 1/0 every cycle mid-frame -> no byte is lost or duplicated, and s_axis_tready[grant] mirrors m_axis_tready exactly.
- Reset mid-frame: rst_n low at byte 20 -> all outputs go to reset values at once; after release, port 1's pending frame is granted normally.
- Watchdog (macro on, TIMEOUT_CYCLES=16): port 0 stops tvalid at byte 10 for 20 cycles -> after 16 stall cycles a single 0x00 beat with tlast=1, tuser=1 is emitted and abort_pulse fires; the rest of port 0's frame is drained; port 1 is then granted.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
//
// Frame-level round-robin arbiter that shares the single 8-bit AXI-stream TX
// input of the 10/100 MII MAC between PORTS frame sources. It runs in the MAC
// tx_clk domain, directly upstream of the MAC tx_axis port. Once a port is
// granted, its whole frame passes through combinationally and uninterrupted.
// Only tlast releases the grant. Every frame is followed by at least one IDLE
// cycle.
//
// Optional feature macro: ETH_TX_ARB_WATCHDOG_EN
//   When it is defined, a 16-bit stall counter watches the granted port
//   during a frame. After TIMEOUT_CYCLES consecutive cycles without tvalid,
//   the arbiter performs two steps:
//   - It emits one 0x00 beat with tlast=1 and tuser=1, so that the MAC drops
//     the frame, and it pulses abort_pulse.
//   - It then drains the rest of the source frame.
//   When the macro is undefined, there is no counter and abort_pulse is 0.
//
// Ports:
//   clk, rst_n       MAC tx_clk, asynchronous active-low reset
//   s_axis_*         PORTS source streams (tdata lane i = bits [8i+7:8i])
//   m_axis_*         8-bit stream towards MAC tx_axis
//   grant_valid      a frame is in progress
//   grant_idx        index of the granted port
//   frame_count      completed (or aborted) output frames, wraps at 16 bits
//   abort_pulse      one-cycle pulse after an aborted frame's error beat
// ---------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int PORTS          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PORTS*8-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]   s_axis_tvalid,
    output logic [PORTS-1:0]   s_axis_tready,
    input  logic [PORTS-1:0]   s_axis_tlast,
    input  logic [PORTS-1:0]   s_axis_tuser,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               grant_valid,
    output logic [2:0]         grant_idx,
    output logic [15:0]        frame_count,
    output logic               abort_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q,       state_d;
    logic [2:0]  last_grant_q,  last_grant_d;
    logic [2:0]  grant_idx_q,   grant_idx_d;
    logic        grant_valid_q, grant_valid_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic [7:0]       sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic             sel_user_s;
    logic [PORTS-1:0] grant_onehot_s;
    logic             pick_found_s;
    logic [2:0]       pick_idx_s;

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_M1_C = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_q, stall_d;
    logic        abort_pulse_q, abort_pulse_d;
`endif

    // Granted-port stream mux (written as a compare loop so the 3-bit index never overruns narrow vectors)
    always_comb begin
        sel_data_s     = 8'h00;
        sel_valid_s    = 1'b0;
        sel_last_s     = 1'b0;
        sel_user_s     = 1'b0;
        grant_onehot_s = '0;
        for (int i = 0; i < PORTS; i++) begin
            grant_onehot_s[i] = (grant_idx_q == 3'(i));
            sel_data_s  = grant_onehot_s[i] ? s_axis_tdata[8*i +: 8] : sel_data_s;
            sel_valid_s = grant_onehot_s[i] ? s_axis_tvalid[i]       : sel_valid_s;
            sel_last_s  = grant_onehot_s[i] ? s_axis_tlast[i]        : sel_last_s;
            sel_user_s  = grant_onehot_s[i] ? s_axis_tuser[i]        : sel_user_s;
        end
    end

    // Round-robin pick: the first valid port after last_grant; offsets scanned high-to-low so the nearest wins
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = 3'd0;
        for (int k = PORTS; k >= 1; k--) begin
            for (int j = 0; j < PORTS; j++) begin
                pick_found_s = (s_axis_tvalid[j] && (j == ((int'(last_grant_q) + k) % PORTS)))
                               ? 1'b1 : pick_found_s;
                pick_idx_s   = (s_axis_tvalid[j] && (j == ((int'(last_grant_q) + k) % PORTS)))
                               ? 3'(j) : pick_idx_s;
            end
        end
    end

    // Next-state and stream outputs for the IDLE/XFER/ABORT/DRAIN controller
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        frame_count_d = frame_count_q;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        stall_d       = stall_q;
        abort_pulse_d = 1'b0;
`endif
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_idx_d   = pick_idx_s;
                    grant_valid_d = 1'b1;
                    state_d       = ST_XFER;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    stall_d       = 16'd0;
`endif
                end else begin
                    grant_valid_d = 1'b0;
                end
            end

            ST_XFER: begin
                m_axis_tdata  = sel_data_s;
                m_axis_tvalid = sel_valid_s;
                m_axis_tlast  = sel_last_s;
                m_axis_tuser  = sel_user_s;
                s_axis_tready = grant_onehot_s & {PORTS{m_axis_tready}};
                if (sel_valid_s && m_axis_tready && sel_last_s) begin
                    last_grant_d  = grant_idx_q;
                    grant_valid_d = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end else begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    // stall_q counts the stalled cycles that came before this one.
                    if (sel_valid_s) begin
                        stall_d = 16'd0;
                    end else if (stall_q >= TIMEOUT_M1_C) begin
                        state_d = ST_ABORT;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
`else
                    state_d = ST_XFER;
`endif
                end
            end

`ifdef ETH_TX_ARB_WATCHDOG_EN
            ST_ABORT: begin
                // A single error beat makes the MAC discard the partial frame.
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    abort_pulse_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_DRAIN;
                end else begin
                    state_d = ST_ABORT;
                end
            end

            ST_DRAIN: begin
                s_axis_tready = grant_onehot_s;
                if (sel_valid_s && sel_last_s) begin
                    last_grant_d  = grant_idx_q;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
`endif

            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 3'(PORTS - 1);
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    // Watchdog stall counter and abort pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= 16'd0;
            abort_pulse_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

    assign abort_pulse = abort_pulse_q;
`else
    assign abort_pulse = 1'b0;
`endif

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for eth_tx_arbiter (PORTS=2, TIMEOUT_CYCLES=16).
//
// Each source port is a queue of beats. A frame-level model tracks two
// things:
//   - which port owns the output;
//   - the expected frame count and frame order.
// Every cycle, the model compares the DUT against these rules:
//   - During IDLE, no output activity and no ready.
//   - While a frame is busy, the granted port's head beat appears on the
//     output, and ready mirrors m_axis_tready on that port only.
//   - Round-robin order holds from the last grant.
// After each scenario, literal expectations (frame order, counts) pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_eth_tx_arbiter;
    localparam int PORTS = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [PORTS*8-1:0]  s_axis_tdata;
    logic [PORTS-1:0]    s_axis_tvalid;
    logic [PORTS-1:0]    s_axis_tready;
    logic [PORTS-1:0]    s_axis_tlast;
    logic [PORTS-1:0]    s_axis_tuser;
    logic [7:0]          m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic                m_axis_tuser;
    logic                grant_valid;
    logic [2:0]          grant_idx;
    logic [15:0]         frame_count;
    logic                abort_pulse;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.PORTS(PORTS), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .frame_count   (frame_count),
        .abort_pulse   (abort_pulse)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t srcq [PORTS][$];
    bit    en [PORTS];
    bit    hs [PORTS];
    int    popped [PORTS];
    bit    toggle_ready;
    bit    model_en;

    // frame-level model
    bit busy;
    int owner;
    int last_g;
    int exp_count;
    int log_q [$];
    int out_bytes;
    int abort_beats;
    int abort_pulses;
    int p1_beats;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return -1;
    endfunction

    task automatic push_frame(input int p, input int len, input int start, input bit u);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = 8'(start + i);
            b.l = (i == len - 1);
            b.u = u;
            srcq[p].push_back(b);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            if (en[p] && srcq[p].size() > 0) begin
                s_axis_tvalid[p]       = 1'b1;
                s_axis_tdata[8*p +: 8] = srcq[p][0].d;
                s_axis_tlast[p]        = srcq[p][0].l;
                s_axis_tuser[p]        = srcq[p][0].u;
            end else begin
                s_axis_tvalid[p]       = 1'b0;
                s_axis_tdata[8*p +: 8] = 8'h00;
                s_axis_tlast[p]        = 1'b0;
                s_axis_tuser[p]        = 1'b0;
            end
        end
    endtask

    task automatic compare_cycle();
        logic [PORTS-1:0] exp_rdy;
        for (int p = 0; p < PORTS; p++) hs[p] = s_axis_tvalid[p] & s_axis_tready[p];
        if (!rst_n) begin
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_m_tlast", m_axis_tlast, 0);
            chk("rst_m_tuser", m_axis_tuser, 0);
            chk("rst_m_tdata", m_axis_tdata, 0);
            chk("rst_s_tready", s_axis_tready, 0);
            chk("rst_grant_valid", grant_valid, 0);
            chk("rst_grant_idx", grant_idx, 0);
            chk("rst_frame_count", frame_count, 0);
            chk("rst_abort_pulse", abort_pulse, 0);
            busy = 0; last_g = PORTS - 1; exp_count = 0; log_q.delete(); out_bytes = 0;
            abort_beats = 0; abort_pulses = 0; p1_beats = 0;
            return;
        end
        if (abort_pulse) abort_pulses++;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast && m_axis_tuser &&
            m_axis_tdata == 8'h00 && s_axis_tready == '0) abort_beats++;
        if (m_axis_tvalid && m_axis_tready && grant_idx == 3'd1) p1_beats++;
        if (!model_en) return;

        chk("abort_pulse", abort_pulse, 0);
        chk("frame_count", frame_count, exp_count);
        if (!busy) begin
            chk("idle_m_tvalid", m_axis_tvalid, 0);
            chk("idle_s_tready", s_axis_tready, 0);
            chk("idle_grant_valid", grant_valid, 0);
            for (int k = 1; k <= PORTS; k++) begin
                int p;
                p = (last_g + k) % PORTS;
                if (!busy && en[p] && srcq[p].size() > 0) begin
                    busy  = 1;
                    owner = p;
                end
            end
        end else begin
            chk("grant_valid", grant_valid, 1);
            chk("grant_idx", grant_idx, owner);
            exp_rdy = '0;
            exp_rdy[owner] = m_axis_tready;
            chk("s_tready", s_axis_tready, exp_rdy);
            if (en[owner] && srcq[owner].size() > 0) begin
                chk("m_tvalid", m_axis_tvalid, 1);
                chk("m_tdata", m_axis_tdata, srcq[owner][0].d);
                chk("m_tlast", m_axis_tlast, srcq[owner][0].l);
                chk("m_tuser", m_axis_tuser, srcq[owner][0].u);
                if (m_axis_tready) begin
                    out_bytes++;
                    if (srcq[owner][0].l) begin
                        exp_count = (exp_count + 1) % 65536;
                        last_g    = owner;
                        log_q.push_back(owner);
                        busy      = 0;
                    end
                end
            end else begin
                chk("stall_m_tvalid", m_axis_tvalid, 0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTS; p++) begin
            if (hs[p]) begin
                void'(srcq[p].pop_front());
                popped[p]++;
            end
        end
        if (toggle_ready) m_axis_tready = ~m_axis_tready;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            en[p] = 0;
            srcq[p].delete();
            popped[p] = 0;
            hs[p] = 0;
        end
        toggle_ready  = 0;
        m_axis_tready = 1'b1;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_done(input string name, input int maxc);
        int n;
        n = 0;
        while ((srcq[0].size() > 0 || srcq[1].size() > 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        chk(name, (n < maxc), 1);
    endtask

    initial begin
        int n;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b1; toggle_ready = 0; model_en = 1;
        busy = 0; last_g = PORTS - 1; exp_count = 0; owner = 0;
        #2;
        do_reset();
        tick();
        chk("post_reset_grant_idx", grant_idx, 0);
        chk("post_reset_frame_count", frame_count, 0);

        // single 60-byte frame from port 0
        push_frame(0, 60, 8'h01, 1'b0);
        en[0] = 1; drive();
        run_done("t1_timeout", 400);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_order0", log_at(0), 0);
        chk("t1_bytes", out_bytes, 60);

        // contention: both ports request in the same cycle after reset
        do_reset();
        push_frame(0, 64, 8'h10, 1'b0);
        push_frame(1, 64, 8'h80, 1'b0);
        en[0] = 1; en[1] = 1; drive();
        run_done("t2_timeout", 400);
        chk("t2_frame_count", frame_count, 2);
        chk("t2_order0", log_at(0), 0);
        chk("t2_order1", log_at(1), 1);
        chk("t2_bytes", out_bytes, 128);

        // fairness: port 0 back-to-back, port 1 requests once mid-frame
        do_reset();
        push_frame(0, 6, 8'h01, 1'b0);
        push_frame(0, 6, 8'h11, 1'b0);
        en[0] = 1; drive();
        repeat (3) tick();
        push_frame(1, 6, 8'h21, 1'b1);
        en[1] = 1; drive();
        run_done("t3_timeout", 200);
        chk("t3_frame_count", frame_count, 3);
        chk("t3_order0", log_at(0), 0);
        chk("t3_order1", log_at(1), 1);
        chk("t3_order2", log_at(2), 0);

        // backpressure plus a short source stall, lone requester re-granted
        do_reset();
        push_frame(1, 16, 8'hA0, 1'b0);
        push_frame(1, 16, 8'hB0, 1'b0);
        en[1] = 1; toggle_ready = 1; drive();
        repeat (6) tick();
        en[1] = 0; drive();
        repeat (3) tick();
        en[1] = 1; drive();
        run_done("t4_timeout", 300);
        toggle_ready = 0; m_axis_tready = 1'b1;
        chk("t4_frame_count", frame_count, 2);
        chk("t4_order0", log_at(0), 1);
        chk("t4_order1", log_at(1), 1);
        chk("t4_bytes", out_bytes, 32);

        // reset at byte 20 of port 0, port 1 pending
        do_reset();
        push_frame(0, 30, 8'h01, 1'b0);
        push_frame(1, 8, 8'h60, 1'b0);
        en[0] = 1; en[1] = 1; drive();
        n = 0;
        while (popped[0] < 20 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_wait_timeout", (n < 200), 1);
        rst_n = 1'b0;
        srcq[0].delete(); en[0] = 0; drive();
        #1;
        chk("t5_async_m_tvalid", m_axis_tvalid, 0);
        chk("t5_async_grant_valid", grant_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        run_done("t5_timeout", 100);
        chk("t5_frame_count", frame_count, 1);
        chk("t5_order0", log_at(0), 1);
        chk("t5_bytes", out_bytes, 8);

`ifdef ETH_TX_ARB_WATCHDOG_EN
        // watchdog: port 0 stalls 20 cycles at byte 10
        do_reset();
        model_en = 0;
        push_frame(0, 20, 8'h01, 1'b0);
        push_frame(1, 4, 8'h70, 1'b0);
        en[0] = 1; en[1] = 1; drive();
        n = 0;
        while (popped[0] < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_wait_timeout", (n < 100), 1);
        en[0] = 0; drive();
        repeat (20) tick();
        en[0] = 1; drive();
        n = 0;
        while ((srcq[0].size() > 0 || srcq[1].size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk("t6_timeout", (n < 200), 1);
        tick();
        chk("t6_abort_beats", abort_beats, 1);
        chk("t6_abort_pulses", abort_pulses, 1);
        chk("t6_frame_count", frame_count, 2);
        chk("t6_p1_beats", p1_beats, 4);
        chk("t6_drained", srcq[0].size(), 0);
        model_en = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
